// File: rtl/i2c_slave_pkg.sv
// Shared types and helpers for the I2C target: FSM encoding, byte-lane geometry.
package i2c_slave_pkg;

    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned FIFO_W    = 8 * NUM_BYTES;
    localparam int unsigned COUNT_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_t;

    // LSB position of byte lane idx; lane 0 sits in the top byte
    function automatic logic [6:0] lane_lsb(input logic [3:0] idx);
        return {4'd15 - idx, 3'b000};
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers, registered edge detect and START/STOP detection.
module i2c_bus_sync (
    input  logic clk_100m,
    input  logic rstn,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start,
    output logic stop
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_q;
    logic       sda_q;

    // Idle bus is high, so reset the pipeline high to avoid false events
    always_ff @(posedge clk_100m or negedge rstn) begin
        if (!rstn) begin
            scl_ff   <= 2'b11;
            sda_ff   <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            sda_s    <= 1'b1;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_ff   <= {scl_ff[0], scl};
            sda_ff   <= {sda_ff[0], sda};
            scl_q    <= scl_ff[1];
            sda_q    <= sda_ff[1];
            scl_rise <= scl_ff[1] & ~scl_q;
            scl_fall <= ~scl_ff[1] & scl_q;
            sda_s    <= sda_ff[1];
            start    <= scl_ff[1] & scl_q & sda_q & ~sda_ff[1];
            stop     <= scl_ff[1] & scl_q & ~sda_q & sda_ff[1];
        end
    end

endmodule

// File: rtl/i2c_slave.sv
// I2C target with fixed 7-bit address; 16-byte receive and transmit vectors.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  SLV_ADR = 7'h2d,
    parameter int unsigned HOLD    = 4
) (
    input  logic              clk_100m,
    input  logic              rstn,
    input  logic [FIFO_W-1:0] slv_tfifo,
    output logic [FIFO_W-1:0] slv_rfifo,
    output logic [7:0]        slv_status,
    output logic              slv_done,
    input  logic              scl,
    inout  wire               sda
);

    localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic scl_rise, scl_fall, sda_s, start, stop;

    i2c_bus_sync u_sync (
        .clk_100m (clk_100m),
        .rstn     (rstn),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start    (start),
        .stop     (stop)
    );

    state_t              state, state_nxt;
    logic [2:0]          bit_cnt, bit_cnt_nxt;
    logic [6:0]          shreg, shreg_nxt;
    logic [COUNT_W-1:0]  count, count_nxt;
    logic                rw, rw_nxt;
    logic                ovf, ovf_nxt;
    logic                busy, busy_nxt;
    logic                ack_arm, ack_arm_nxt;
    logic [FIFO_W-1:0]   rfifo_nxt;
    logic                done_nxt;
    logic                sda_low, sda_low_nxt;
    logic                pend_low, pend_low_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic                drive_req, drive_low;
    logic [7:0]          rx_byte, tx_byte;

    assign sda        = sda_low ? 1'b0 : 1'bz;
    assign slv_status = {busy, ovf, rw, count};

    always_ff @(posedge clk_100m or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            count     <= '0;
            rw        <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            ack_arm   <= 1'b0;
            slv_rfifo <= '0;
            slv_done  <= 1'b0;
            sda_low   <= 1'b0;
            pend_low  <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            count     <= count_nxt;
            rw        <= rw_nxt;
            ovf       <= ovf_nxt;
            busy      <= busy_nxt;
            ack_arm   <= ack_arm_nxt;
            slv_rfifo <= rfifo_nxt;
            slv_done  <= done_nxt;
            sda_low   <= sda_low_nxt;
            pend_low  <= pend_low_nxt;
            hold_cnt  <= hold_cnt_nxt;
        end
    end

    // ack_arm marks that the 9th SCL rise of an ACK slot has been seen
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        count_nxt    = count;
        rw_nxt       = rw;
        ovf_nxt      = ovf;
        busy_nxt     = busy;
        ack_arm_nxt  = ack_arm;
        rfifo_nxt    = slv_rfifo;
        done_nxt     = 1'b0;
        sda_low_nxt  = sda_low;
        pend_low_nxt = pend_low;
        hold_cnt_nxt = hold_cnt;
        drive_req    = 1'b0;
        drive_low    = 1'b0;
        rx_byte      = {shreg, sda_s};
        tx_byte      = slv_tfifo[lane_lsb(count[3:0]) +: 8];

        if (hold_cnt != '0) begin
            hold_cnt_nxt = hold_cnt - HOLD_W'(1);
            if (hold_cnt == HOLD_W'(1)) begin
                sda_low_nxt = pend_low;
            end
        end

        if (stop) begin
            state_nxt    = ST_IDLE;
            sda_low_nxt  = 1'b0;
            hold_cnt_nxt = '0;
            if (busy) begin
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
            end
        end else if (start) begin
            state_nxt    = ST_ADDR;
            bit_cnt_nxt  = '0;
            ack_arm_nxt  = 1'b0;
            sda_low_nxt  = 1'b0;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte[6:0];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (rx_byte[7:1] == SLV_ADR) begin
                                state_nxt   = ST_ADR_ACK;
                                rw_nxt      = rx_byte[0];
                                busy_nxt    = 1'b1;
                                count_nxt   = '0;
                                ovf_nxt     = 1'b0;
                                ack_arm_nxt = 1'b0;
                            end else begin
                                state_nxt = ST_WAIT_STOP;
                                busy_nxt  = 1'b0;
                            end
                        end
                    end
                end
                ST_ADR_ACK, ST_WR_ACK: begin
                    if (scl_rise) begin
                        ack_arm_nxt = 1'b1;
                    end else if (scl_fall) begin
                        drive_req = 1'b1;
                        if (!ack_arm) begin
                            drive_low = 1'b1;
                        end else begin
                            ack_arm_nxt = 1'b0;
                            bit_cnt_nxt = '0;
                            if (state == ST_ADR_ACK && rw) begin
                                state_nxt = ST_RD_DATA;
                                drive_low = ~tx_byte[7];
                            end else begin
                                state_nxt = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte[6:0];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (count < COUNT_W'(NUM_BYTES)) begin
                                rfifo_nxt[lane_lsb(count[3:0]) +: 8] = rx_byte;
                                count_nxt   = count + COUNT_W'(1);
                                state_nxt   = ST_WR_ACK;
                                ack_arm_nxt = 1'b0;
                            end else begin
                                ovf_nxt   = 1'b1;
                                state_nxt = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (count < COUNT_W'(NUM_BYTES)) begin
                                count_nxt = count + COUNT_W'(1);
                            end
                            state_nxt   = ST_RD_ACK;
                            ack_arm_nxt = 1'b0;
                        end
                    end else if (scl_fall) begin
                        drive_req = 1'b1;
                        drive_low = ~tx_byte[3'd7 - bit_cnt];
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_nxt = ST_WAIT_STOP;
                        end else begin
                            ack_arm_nxt = 1'b1;
                        end
                    end else if (scl_fall) begin
                        drive_req = 1'b1;
                        if (ack_arm) begin
                            ack_arm_nxt = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = ST_RD_DATA;
                            drive_low   = ~tx_byte[7];
                        end
                    end
                end
                ST_WAIT_STOP: begin
                    sda_low_nxt  = 1'b0;
                    hold_cnt_nxt = '0;
                end
                default: ;
            endcase
        end

        // Drive changes are deferred to give the master HOLD cycles of data hold
        if (drive_req) begin
            if (HOLD <= 1) begin
                sda_low_nxt  = drive_low;
                hold_cnt_nxt = '0;
            end else begin
                pend_low_nxt = drive_low;
                hold_cnt_nxt = HOLD_W'(HOLD - 1);
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bus-level master tasks with hand-computed expectations.
module tb_i2c_slave;

    localparam int T = 250;

    logic         clk_100m = 1'b0;
    logic         rstn;
    logic [127:0] slv_tfifo;
    wire  [127:0] slv_rfifo;
    wire  [7:0]   slv_status;
    wire          slv_done;
    logic         scl;
    logic         m_sda_low;
    wire          sda;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave dut (
        .clk_100m   (clk_100m),
        .rstn       (rstn),
        .slv_tfifo  (slv_tfifo),
        .slv_rfifo  (slv_rfifo),
        .slv_status (slv_status),
        .slv_done   (slv_done),
        .scl        (scl),
        .sda        (sda)
    );

    always #5 clk_100m = ~clk_100m;

    always @(negedge clk_100m) begin
        if (slv_done)      done_cnt++;
        if (slv_status[7]) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_bit(input logic b, output logic r);
        #T m_sda_low = ~b;
        #T scl = 1'b1;
        #T r = sda;
        #T scl = 1'b0;
    endtask

    task automatic m_start();
        #T m_sda_low = 1'b0;
        #T scl = 1'b1;
        #T m_sda_low = 1'b1;
        #T scl = 1'b0;
    endtask

    task automatic m_stop();
        #T m_sda_low = 1'b1;
        #T scl = 1'b1;
        #T m_sda_low = 1'b0;
        #T;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(nack, r);
    endtask

    initial begin
        logic       ack;
        logic       r;
        logic [7:0] rd;
        logic [7:0] adr_wr;
        int         d0;
        int         b0;

        rstn      = 1'b0;
        scl       = 1'b1;
        m_sda_low = 1'b0;
        slv_tfifo = 128'h0102030405060708090a0b0c0d0e0f10;
        adr_wr    = 8'h5a;

        // Reset state
        #23;
        chk("rst_status", 128'(slv_status), 128'h00);
        chk("rst_rfifo",  slv_rfifo, 128'h0);
        chk("rst_done",   128'(slv_done), 128'h0);
        chk("rst_sda",    128'(sda), 128'h1);
        #20 rstn = 1'b1;
        #200;

        // Write three bytes to own address
        d0 = done_cnt;
        m_start();
        send_byte(8'h5a, ack);
        chk("wr_adr_ack", 128'(ack), 128'h0);
        chk("wr_busy", 128'(slv_status), 128'h80);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h5a, ack);
            chk("wr_data_ack", 128'(ack), 128'h0);
        end
        chk("wr_status_open", 128'(slv_status), 128'h83);
        m_stop();
        #200;
        chk("wr_rfifo",  slv_rfifo, 128'h5a5a5a00_00000000_00000000_00000000);
        chk("wr_status", 128'(slv_status), 128'h03);
        chk("wr_done",   128'(done_cnt - d0), 128'h1);

        // Wrong address is NACKed and leaves status alone
        d0 = done_cnt;
        b0 = busy_cnt;
        m_start();
        send_byte(8'h58, ack);
        chk("bad_adr_nack", 128'(ack), 128'h1);
        m_stop();
        #200;
        chk("bad_busy",   128'(busy_cnt - b0), 128'h0);
        chk("bad_done",   128'(done_cnt - d0), 128'h0);
        chk("bad_status", 128'(slv_status), 128'h03);
        chk("bad_rfifo",  slv_rfifo, 128'h5a5a5a00_00000000_00000000_00000000);

        // Read two bytes, ACK the first, NACK the second
        d0 = done_cnt;
        m_start();
        send_byte(8'h5b, ack);
        chk("rd_adr_ack", 128'(ack), 128'h0);
        read_byte(1'b0, rd);
        chk("rd_byte0", 128'(rd), 128'h01);
        read_byte(1'b1, rd);
        chk("rd_byte1", 128'(rd), 128'h02);
        #100;
        chk("rd_release", 128'(sda), 128'h1);
        chk("rd_status_open", 128'(slv_status), 128'ha2);
        m_stop();
        #200;
        chk("rd_status", 128'(slv_status), 128'h22);
        chk("rd_done",   128'(done_cnt - d0), 128'h1);

        // Seventeen write bytes: the last one overflows
        d0 = done_cnt;
        m_start();
        send_byte(adr_wr, ack);
        chk("ovf_adr_ack", 128'(ack), 128'h0);
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(8'h10 + i), ack);
            chk("ovf_data_ack", 128'(ack), 128'(i == 16));
        end
        m_stop();
        #200;
        chk("ovf_rfifo",  slv_rfifo, 128'h10111213_14151617_18191a1b_1c1d1e1f);
        chk("ovf_status", 128'(slv_status), 128'h50);
        chk("ovf_done",   128'(done_cnt - d0), 128'h1);

        // Write one byte, repeated START, read one byte
        d0 = done_cnt;
        m_start();
        send_byte(8'h5a, ack);
        chk("rs_wadr_ack", 128'(ack), 128'h0);
        send_byte(8'ha5, ack);
        chk("rs_wdata_ack", 128'(ack), 128'h0);
        chk("rs_wstatus", 128'(slv_status), 128'h81);
        m_start();
        send_byte(8'h5b, ack);
        chk("rs_radr_ack", 128'(ack), 128'h0);
        chk("rs_rstatus", 128'(slv_status), 128'ha0);
        read_byte(1'b1, rd);
        chk("rs_rbyte", 128'(rd), 128'h01);
        chk("rs_no_early_done", 128'(done_cnt - d0), 128'h0);
        m_stop();
        #200;
        chk("rs_status", 128'(slv_status), 128'h21);
        chk("rs_done",   128'(done_cnt - d0), 128'h1);
        chk("rs_rfifo",  slv_rfifo, 128'ha5111213_14151617_18191a1b_1c1d1e1f);

        // Reset while the target holds the address ACK low
        m_start();
        for (int i = 7; i >= 0; i--) bus_bit(adr_wr[i], r);
        m_sda_low = 1'b0;
        #T;
        chk("mid_ack_low", 128'(sda), 128'h0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_sda",    128'(sda), 128'h1);
        chk("mid_rst_status", 128'(slv_status), 128'h00);
        chk("mid_rst_rfifo",  slv_rfifo, 128'h0);
        chk("mid_rst_done",   128'(slv_done), 128'h0);
        #T scl = 1'b1;
        #50 rstn = 1'b1;
        #200;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
